// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, 32x32 register file with write-through read,
// instruction decode and load-use hazard detection feeding execute.
module decode_stage #(
  parameter int              XLEN      = 32,
  parameter int              ILEN      = 32,
  parameter logic [ILEN-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_in,
  input  logic            flush_in,
  input  logic [ILEN-1:0] instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] pc_plus4_in,
  input  logic            pred_taken_in,
  input  logic            icache_ready_in,
  input  logic            wb_we_in,
  input  logic [4:0]      wb_rd_in,
  input  logic [XLEN-1:0] wb_data_in,
  input  logic            ex_mem_read_in,
  input  logic [4:0]      ex_rd_in,
  output logic            hazard_stall_out,
  output logic            valid_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4_out,
  output logic            pred_taken_out,
  output logic [4:0]      rs1_out,
  output logic [4:0]      rs2_out,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] rs1_data_out,
  output logic [XLEN-1:0] rs2_data_out,
  output logic [XLEN-1:0] imm_out,
  output logic [3:0]      alu_op_out,
  output logic            alu_src_a_pc_out,
  output logic            alu_src_b_imm_out,
  output logic            mem_read_out,
  output logic            mem_write_out,
  output logic [1:0]      mem_size_out,
  output logic            mem_unsigned_out,
  output logic            reg_write_out,
  output logic            branch_out,
  output logic            jump_out,
  output logic            illegal_out
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [3:0]      alu_op;
    logic            src_a_pc;
    logic            src_b_imm;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            branch;
    logic            jump;
    logic            illegal;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            has_rd;
  } ctrl_t;

  logic [ILEN-1:0] instr_q;
  logic [XLEN-1:0] pc_q, pc_plus4_q;
  logic            pred_q, valid_q;
  logic [XLEN-1:0] rf [32];
  ctrl_t           ctl;
  logic            issue;

  // IF/ID register
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      pred_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else if (flush_in) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (!(stall_in || hazard_stall_out)) begin
      instr_q    <= instr_in;
      pc_q       <= pc_in;
      pc_plus4_q <= pc_plus4_in;
      pred_q     <= pred_taken_in;
      valid_q    <= icache_ready_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_we_in && wb_rd_in != 5'd0) begin
      rf[wb_rd_in] <= wb_data_in;
    end
  end

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode  = instr_q[6:0];
  assign funct3  = instr_q[14:12];
  assign funct7  = instr_q[31:25];
  assign rs1_out = instr_q[19:15];
  assign rs2_out = instr_q[24:20];

  // Same-cycle writeback is forwarded so execute never sees a stale operand.
  assign rs1_data_out = (rs1_out == 5'd0) ? '0 :
                        (wb_we_in && wb_rd_in == rs1_out) ? wb_data_in : rf[rs1_out];
  assign rs2_data_out = (rs2_out == 5'd0) ? '0 :
                        (wb_we_in && wb_rd_in == rs2_out) ? wb_data_in : rf[rs2_out];

  function automatic logic [3:0] alu_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_f3 = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_f3 = ALU_SLL;
      3'd2:    alu_f3 = ALU_SLT;
      3'd3:    alu_f3 = ALU_SLTU;
      3'd4:    alu_f3 = ALU_XOR;
      3'd5:    alu_f3 = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_f3 = ALU_OR;
      default: alu_f3 = ALU_AND;
    endcase
  endfunction

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{21{instr_q[31]}}, instr_q[30:20]};
  assign imm_s = {{21{instr_q[31]}}, instr_q[30:25], instr_q[11:7]};
  assign imm_b = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_u = {instr_q[31:12], 12'b0};
  assign imm_j = {{12{instr_q[31]}}, instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

  always_comb begin
    ctl        = '0;
    ctl.alu_op = ALU_ADD;
    ctl.has_rd = 1'b1;
    case (opcode)
      OPC_LUI: begin
        ctl.imm = imm_u; ctl.alu_op = ALU_PASSB; ctl.src_b_imm = 1'b1; ctl.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        ctl.imm = imm_u; ctl.src_a_pc = 1'b1; ctl.src_b_imm = 1'b1; ctl.reg_write = 1'b1;
      end
      OPC_JAL: begin
        ctl.imm = imm_j; ctl.src_a_pc = 1'b1; ctl.src_b_imm = 1'b1;
        ctl.reg_write = 1'b1; ctl.jump = 1'b1;
      end
      OPC_JALR: begin
        ctl.imm = imm_i; ctl.src_a_pc = 1'b1; ctl.src_b_imm = 1'b1;
        ctl.reg_write = 1'b1; ctl.jump = 1'b1; ctl.uses_rs1 = 1'b1;
        ctl.illegal = (funct3 != 3'd0);
      end
      OPC_BRANCH: begin
        ctl.imm = imm_b; ctl.alu_op = ALU_SUB; ctl.branch = 1'b1; ctl.has_rd = 1'b0;
        ctl.uses_rs1 = 1'b1; ctl.uses_rs2 = 1'b1;
        ctl.illegal = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      OPC_LOAD: begin
        ctl.imm = imm_i; ctl.src_b_imm = 1'b1; ctl.mem_read = 1'b1;
        ctl.reg_write = 1'b1; ctl.uses_rs1 = 1'b1;
        ctl.illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OPC_STORE: begin
        ctl.imm = imm_s; ctl.src_b_imm = 1'b1; ctl.mem_write = 1'b1; ctl.has_rd = 1'b0;
        ctl.uses_rs1 = 1'b1; ctl.uses_rs2 = 1'b1;
        ctl.illegal = (funct3 > 3'd2);
      end
      OPC_OPIMM: begin
        ctl.imm = imm_i; ctl.src_b_imm = 1'b1; ctl.reg_write = 1'b1; ctl.uses_rs1 = 1'b1;
        // funct7[5] only selects SRAI; for other funct3 it is just an immediate bit.
        ctl.alu_op = alu_f3(funct3, (funct3 == 3'd5) && funct7[5]);
        if (funct3 == 3'd1)      ctl.illegal = (funct7 != 7'h00);
        else if (funct3 == 3'd5) ctl.illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
      end
      OPC_OP: begin
        ctl.reg_write = 1'b1; ctl.uses_rs1 = 1'b1; ctl.uses_rs2 = 1'b1;
        ctl.alu_op  = alu_f3(funct3, funct7[5]);
        ctl.illegal = (funct7 != 7'h00) &&
                      !((funct7 == 7'h20) && (funct3 == 3'd0 || funct3 == 3'd5));
      end
      default: ctl.illegal = 1'b1;
    endcase
    if (ctl.illegal) begin
      ctl.reg_write = 1'b0; ctl.mem_read = 1'b0; ctl.mem_write = 1'b0;
      ctl.branch    = 1'b0; ctl.jump     = 1'b0;
      ctl.uses_rs1  = 1'b0; ctl.uses_rs2 = 1'b0;
    end
  end

  assign hazard_stall_out = valid_q && ex_mem_read_in && (ex_rd_in != 5'd0) &&
                            ((ctl.uses_rs1 && rs1_out == ex_rd_in) ||
                             (ctl.uses_rs2 && rs2_out == ex_rd_in));
  assign issue = valid_q && !hazard_stall_out;

  assign rd_out            = ctl.has_rd ? instr_q[11:7] : 5'd0;
  assign valid_out         = issue;
  assign pc_out            = pc_q;
  assign pc_plus4_out      = pc_plus4_q;
  assign pred_taken_out    = pred_q;
  assign imm_out           = ctl.imm;
  assign alu_op_out        = ctl.alu_op;
  assign alu_src_a_pc_out  = ctl.src_a_pc;
  assign alu_src_b_imm_out = ctl.src_b_imm;
  assign mem_read_out      = issue && ctl.mem_read;
  assign mem_write_out     = issue && ctl.mem_write;
  assign mem_size_out      = funct3[1:0];
  assign mem_unsigned_out  = funct3[2];
  assign reg_write_out     = issue && ctl.reg_write && (rd_out != 5'd0);
  assign branch_out        = issue && ctl.branch;
  assign jump_out          = issue && ctl.jump;
  assign illegal_out       = valid_q && ctl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: vector table through a scoreboard queue,
// then hand sequences for stall, hazard, flush and reset corners.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        reset, stall_in, flush_in, pred_taken_in, icache_ready_in;
  logic [31:0] instr_in, pc_in, pc_plus4_in, wb_data_in;
  logic        wb_we_in, ex_mem_read_in;
  logic [4:0]  wb_rd_in, ex_rd_in;
  logic        hazard_stall_out, valid_out, pred_taken_out;
  logic [31:0] pc_out, pc_plus4_out, rs1_data_out, rs2_data_out, imm_out;
  logic [4:0]  rs1_out, rs2_out, rd_out;
  logic [3:0]  alu_op_out;
  logic        alu_src_a_pc_out, alu_src_b_imm_out, mem_read_out, mem_write_out;
  logic [1:0]  mem_size_out;
  logic        mem_unsigned_out, reg_write_out, branch_out, jump_out, illegal_out;

  decode_stage dut (
    .clk(clk), .reset(reset), .stall_in(stall_in), .flush_in(flush_in),
    .instr_in(instr_in), .pc_in(pc_in), .pc_plus4_in(pc_plus4_in),
    .pred_taken_in(pred_taken_in), .icache_ready_in(icache_ready_in),
    .wb_we_in(wb_we_in), .wb_rd_in(wb_rd_in), .wb_data_in(wb_data_in),
    .ex_mem_read_in(ex_mem_read_in), .ex_rd_in(ex_rd_in),
    .hazard_stall_out(hazard_stall_out), .valid_out(valid_out),
    .pc_out(pc_out), .pc_plus4_out(pc_plus4_out), .pred_taken_out(pred_taken_out),
    .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out),
    .rs1_data_out(rs1_data_out), .rs2_data_out(rs2_data_out), .imm_out(imm_out),
    .alu_op_out(alu_op_out), .alu_src_a_pc_out(alu_src_a_pc_out),
    .alu_src_b_imm_out(alu_src_b_imm_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .mem_size_out(mem_size_out),
    .mem_unsigned_out(mem_unsigned_out), .reg_write_out(reg_write_out),
    .branch_out(branch_out), .jump_out(jump_out), .illegal_out(illegal_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, hazard;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        srcb, rw, mr, mw, br, jmp, ill;
    logic [31:0] rs1d, rs2d, pc;
    logic        pred;
  } exp_t;

  typedef struct {
    logic [31:0] instr, pc;
    logic        pred, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exr;
    logic [4:0]  exrd;
    exp_t        e;
  } vec_t;

  int   checks = 0, failures = 0;
  exp_t sb[$];
  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic exp_t me(input logic v, hz, input logic [4:0] rd, input logic [31:0] imm,
                              input logic [3:0] alu, input logic srcb, rw, mr, mw, br, jmp, ill,
                              input logic [31:0] rs1d, rs2d);
    exp_t e;
    e.valid = v; e.hazard = hz; e.rd = rd; e.imm = imm; e.alu = alu; e.srcb = srcb;
    e.rw = rw; e.mr = mr; e.mw = mw; e.br = br; e.jmp = jmp; e.ill = ill;
    e.rs1d = rs1d; e.rs2d = rs2d; e.pc = '0; e.pred = 1'b0;
    return e;
  endfunction

  task automatic addv(input logic [31:0] instr, pc, input logic pred, wb_we,
                      input logic [4:0] wb_rd, input logic [31:0] wb_data,
                      input logic exr, input logic [4:0] exrd, input exp_t e);
    vec_t v;
    v.instr = instr; v.pc = pc; v.pred = pred; v.wb_we = wb_we; v.wb_rd = wb_rd;
    v.wb_data = wb_data; v.exr = exr; v.exrd = exrd; v.e = e;
    v.e.pc = pc; v.e.pred = pred;
    vt.push_back(v);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; stall_in = 0; flush_in = 0; instr_in = 32'h13; pc_in = 0; pc_plus4_in = 4;
    pred_taken_in = 0; icache_ready_in = 0; wb_we_in = 0; wb_rd_in = 0; wb_data_in = 0;
    ex_mem_read_in = 0; ex_rd_in = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_hazard", 32'(hazard_stall_out), 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_illegal", 32'(illegal_out), 32'd0);
    chk("rst_rw", 32'(reg_write_out), 32'd0);
    reset = 1'b0;

    //        instr         pc       pred we rd dat           exr exrd
    addv(32'h00500093, 32'h100, 0, 0, 0, 0, 0, 0,
         me(1,0, 1, 32'd5,        0, 1,1,0,0,0,0,0, 0, 0));
    addv(32'h000101B3, 32'h104, 0, 1, 2, 32'hDEADBEEF, 0, 0,
         me(1,0, 3, 32'd0,        0, 0,1,0,0,0,0,0, 32'hDEADBEEF, 0));
    addv(32'h00210233, 32'h108, 0, 0, 0, 0, 0, 0,
         me(1,0, 4, 32'd0,        0, 0,1,0,0,0,0,0, 32'hDEADBEEF, 32'hDEADBEEF));
    addv(32'h000002B3, 32'h10C, 0, 1, 0, 32'h55, 0, 0,
         me(1,0, 5, 32'd0,        0, 0,1,0,0,0,0,0, 0, 0));
    addv(32'hFE000CE3, 32'h110, 1, 0, 0, 0, 0, 0,
         me(1,0, 0, 32'hFFFFFFF8, 1, 0,0,0,0,1,0,0, 0, 0));
    addv(32'h123452B7, 32'h114, 0, 0, 0, 0, 1, 5,
         me(1,0, 5, 32'h12345000, 10,1,1,0,0,0,0,0, 0, 0));
    addv(32'h00532623, 32'h118, 0, 0, 0, 0, 0, 0,
         me(1,0, 0, 32'd12,       0, 1,0,0,1,0,0,0, 0, 0));
    addv(32'hFFC0A383, 32'h11C, 0, 0, 0, 0, 0, 0,
         me(1,0, 7, 32'hFFFFFFFC, 0, 1,1,1,0,0,0,0, 0, 0));
    addv(32'h40208433, 32'h120, 0, 0, 0, 0, 0, 0,
         me(1,0, 8, 32'd0,        1, 0,1,0,0,0,0,0, 0, 32'hDEADBEEF));
    addv(32'h4030D493, 32'h124, 0, 0, 0, 0, 0, 0,
         me(1,0, 9, 32'h00000403, 7, 1,1,0,0,0,0,0, 0, 0));
    addv(32'h010000EF, 32'h128, 0, 0, 0, 0, 0, 0,
         me(1,0, 1, 32'd16,       0, 1,1,0,0,0,1,0, 0, 0));
    addv(32'h000000FF, 32'h12C, 0, 0, 0, 0, 0, 0,
         me(1,0, 1, 32'd0,        0, 0,0,0,0,0,0,1, 0, 0));
    addv(32'h00000013, 32'h130, 0, 0, 0, 0, 0, 0,
         me(1,0, 0, 32'd0,        0, 1,0,0,0,0,0,0, 0, 0));

    for (int i = 0; i < vt.size(); i++) begin
      exp_t x;
      ex_mem_read_in = 1'b0;
      instr_in = vt[i].instr; pc_in = vt[i].pc; pc_plus4_in = vt[i].pc + 32'd4;
      pred_taken_in = vt[i].pred; icache_ready_in = 1'b1;
      sb.push_back(vt[i].e);
      @(posedge clk); #1;
      wb_we_in = vt[i].wb_we; wb_rd_in = vt[i].wb_rd; wb_data_in = vt[i].wb_data;
      ex_mem_read_in = vt[i].exr; ex_rd_in = vt[i].exrd;
      #1;
      x = sb.pop_front();
      chk($sformatf("v%0d_valid", i), 32'(valid_out), 32'(x.valid));
      chk($sformatf("v%0d_hazard", i), 32'(hazard_stall_out), 32'(x.hazard));
      chk($sformatf("v%0d_rd", i), 32'(rd_out), 32'(x.rd));
      chk($sformatf("v%0d_imm", i), imm_out, x.imm);
      chk($sformatf("v%0d_alu", i), 32'(alu_op_out), 32'(x.alu));
      chk($sformatf("v%0d_srcb", i), 32'(alu_src_b_imm_out), 32'(x.srcb));
      chk($sformatf("v%0d_ctl", i),
          32'({reg_write_out, mem_read_out, mem_write_out, branch_out, jump_out, illegal_out}),
          32'({x.rw, x.mr, x.mw, x.br, x.jmp, x.ill}));
      chk($sformatf("v%0d_rs1d", i), rs1_data_out, x.rs1d);
      chk($sformatf("v%0d_rs2d", i), rs2_data_out, x.rs2d);
      chk($sformatf("v%0d_pc", i), pc_out, x.pc);
      chk($sformatf("v%0d_pc4", i), pc_plus4_out, x.pc + 32'd4);
      chk($sformatf("v%0d_pred", i), 32'(pred_taken_out), 32'(x.pred));
    end
    ex_mem_read_in = 1'b0;
    @(posedge clk); #1;
    wb_we_in = 1'b0;

    // load-use: add x6,x5,x7 behind a load to x5, then to x7
    instr_in = 32'h00728333; pc_in = 32'h200; pc_plus4_in = 32'h204; pred_taken_in = 0;
    @(posedge clk); #1;
    ex_mem_read_in = 1'b1; ex_rd_in = 5'd5; #1;
    chk("lu_hazard", 32'(hazard_stall_out), 32'd1);
    chk("lu_valid", 32'(valid_out), 32'd0);
    chk("lu_rw", 32'(reg_write_out), 32'd0);
    instr_in = 32'h00500093; pc_in = 32'h300; pc_plus4_in = 32'h304;
    repeat (2) @(posedge clk);
    #1;
    chk("lu_hold_pc", pc_out, 32'h200);
    chk("lu_hold_rd", 32'(rd_out), 32'd6);
    ex_rd_in = 5'd7; #1;
    chk("lu_rs2_hazard", 32'(hazard_stall_out), 32'd1);
    ex_mem_read_in = 1'b0; #1;
    chk("lu_release_valid", 32'(valid_out), 32'd1);
    chk("lu_release_rw", 32'(reg_write_out), 32'd1);

    // stall_in alone holds the stage for 3 cycles
    @(posedge clk); #1;
    stall_in = 1'b1; instr_in = 32'h00728333; pc_in = 32'h400; pc_plus4_in = 32'h404;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_pc", c), pc_out, 32'h300);
      chk($sformatf("stall%0d_imm", c), imm_out, 32'd5);
      chk($sformatf("stall%0d_valid", c), 32'(valid_out), 32'd1);
    end

    // flush beats stall
    flush_in = 1'b1;
    @(posedge clk); #1;
    flush_in = 1'b0; stall_in = 1'b0;
    chk("flush_valid", 32'(valid_out), 32'd0);
    chk("flush_nop_rd", 32'(rd_out), 32'd0);
    chk("flush_nop_imm", imm_out, 32'd0);
    chk("flush_rw", 32'(reg_write_out), 32'd0);
    chk("flush_illegal", 32'(illegal_out), 32'd0);

    // icache not ready loads a bubble
    icache_ready_in = 1'b0;
    @(posedge clk); #1;
    chk("nready_valid", 32'(valid_out), 32'd0);
    chk("nready_pc", pc_out, 32'h400);
    icache_ready_in = 1'b1;

    // flush and hazard in the same cycle
    @(posedge clk); #1;
    ex_mem_read_in = 1'b1; ex_rd_in = 5'd5; #1;
    chk("fh_hazard_pre", 32'(hazard_stall_out), 32'd1);
    flush_in = 1'b1;
    @(posedge clk); #1;
    flush_in = 1'b0;
    chk("fh_valid", 32'(valid_out), 32'd0);
    chk("fh_hazard", 32'(hazard_stall_out), 32'd0);
    ex_mem_read_in = 1'b0;

    // reset during a stall clears IF/ID and the register file
    wb_we_in = 1'b1; wb_rd_in = 5'd10; wb_data_in = 32'hCAFEF00D;
    instr_in = 32'h000505B3; pc_in = 32'h500; pc_plus4_in = 32'h504;
    @(posedge clk); #1;
    wb_we_in = 1'b0;
    @(posedge clk); #1;
    chk("rf_x10", rs1_data_out, 32'hCAFEF00D);
    stall_in = 1'b1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst2_valid", 32'(valid_out), 32'd0);
    chk("rst2_pc", pc_out, 32'd0);
    stall_in = 1'b0;
    @(posedge clk); #1;
    chk("rst2_reload_valid", 32'(valid_out), 32'd1);
    chk("rst2_rf_cleared", rs1_data_out, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Second pipeline stage of the in-order RV32I core, directly downstream of fetch. Owns the IF/ID pipeline register, the 32x32 integer register file, instruction decode and load-use hazard detection. Consumes fetch's instruction, PC, PC+4 and prediction flag. Produces register operands, immediate and control bundle for execute, plus a stall back to fetch.

Parameters:
XLEN, 32, datapath and register width
ILEN, 32, instruction width
NOP_INSTR, 32'h00000013, instruction loaded into IF/ID on reset/flush (addi x0,x0,0)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
stall_in  in  1  downstream stall (icache/dcache miss); hold IF/ID
flush_in  in  1  squash IF/ID (branch redirect, misprediction, exception)
instr_in  in  ILEN  instruction from fetch
pc_in  in  XLEN  PC of instr_in
pc_plus4_in  in  XLEN  next-PC from fetch
pred_taken_in  in  1  fetch predicted taken
icache_ready_in  in  1  instr_in is valid this cycle
wb_we_in  in  1  writeback enable
wb_rd_in  in  5  writeback destination
wb_data_in  in  XLEN  writeback data
ex_mem_read_in  in  1  instruction currently in execute is a load
ex_rd_in  in  5  destination of instruction in execute
hazard_stall_out  out  1  load-use stall request to fetch
valid_out  out  1  decoded instruction valid for execute
pc_out, pc_plus4_out  out  XLEN  registered pc_in/pc_plus4_in
pred_taken_out  out  1  registered pred_taken_in
rs1_out, rs2_out, rd_out  out  5  register indices
rs1_data_out, rs2_data_out  out  XLEN  register file read data
imm_out  out  XLEN  sign-extended immediate
alu_op_out  out  4  0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 PASSB
alu_src_a_pc_out  out  1  operand A = PC (AUIPC, JAL, JALR link)
alu_src_b_imm_out  out  1  operand B = imm
mem_read_out, mem_write_out  out  1  load/store
mem_size_out  out  2  0 byte,1 half,2 word (funct3[1:0]); mem_unsigned_out  out 1  funct3[2]
reg_write_out  out  1  writes rd
branch_out, jump_out  out  1  conditional branch / JAL or JALR
illegal_out  out  1  unsupported opcode/funct

Behaviour:
- IF/ID register (instr_q, pc_q, pc_plus4_q, pred_q, valid_q). Reset: instr_q=NOP_INSTR, pc/pc_plus4=0, pred=0, valid=0.
- Priority per clock: reset > flush_in (instr_q=NOP_INSTR, valid_q=0) > stall_in or hazard_stall_out (hold all) > load (valid_q=icache_ready_in).
- Decode is combinational from IF/ID; latency one cycle from fetch output to execute input.
- Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP. Others set illegal_out=1 with reg_write/mem_read/mem_write/branch/jump=0. illegal_out gated by valid_q.
- Immediates: I, S, B (bit0=0), U (low 12 zero), J (bit0=0); all sign-extended from bit 31. R-type imm=0.
- ALU op: OP uses funct3 plus funct7[5] (SUB/SRA); OP-IMM uses funct7[5] only for SRAI; LOAD/STORE/AUIPC/JAL/JALR=ADD; LUI=PASSB; BRANCH=SUB.
- rd_out=0 and reg_write_out=0 for STORE and BRANCH. reg_write_out forced 0 when rd==0.
- Register file: x0 reads 0 always; write on posedge when wb_we_in && wb_rd_in!=0; reset clears all 31 registers. Same-cycle read of wb_rd_in returns wb_data_in (write-through bypass).
- Load-use: hazard_stall_out = valid_q && ex_mem_read_in && ex_rd_in!=0 && ((uses_rs1 && rs1==ex_rd_in) || (uses_rs2 && rs2==ex_rd_in)). uses_rs1 false for LUI/AUIPC/JAL; uses_rs2 true only for OP/STORE/BRANCH.
- While hazard_stall_out=1 or flushed: valid_out=0 and reg_write/mem_read/mem_write/branch/jump=0 (bubble); IF/ID held.
- flush_in and hazard in same cycle: flush wins, next cycle valid_q=0, no stall.

Test Plan:
- Reset then fetch 32'h00500093 (addi x1,x0,5), pc=0x100 -> next cycle valid_out=1, rd=1, imm=5, alu_op=0, alu_src_b_imm=1, reg_write=1, pc_out=0x100.
- wb x2=0xDEADBEEF same cycle as decoding add x3,x2,x0 -> rs1_data_out=0xDEADBEEF (bypass); wb to x0 -> x0 still reads 0.
- ex_mem_read_in=1, ex_rd_in=5, decode add x6,x5,x7 -> hazard_stall_out=1, valid_out=0, IF/ID holds; deassert load -> valid_out=1. Same with lui x5 -> no stall.
- Branch beq with imm -8 (32'hFE000CE3) -> imm_out=0xFFFFFFF8, branch_out=1, alu_op=1, reg_write=0; pred_taken_in=1 propagates to pred_taken_out.
- flush_in with stall_in=1 -> next cycle valid_out=0, instr_q=NOP; stall_in alone holds prior outputs unchanged for 3 cycles.
- Opcode 7'b1111111 -> illegal_out=1, all write enables 0; reset mid-stall -> valid_out=0, register file reads 0.
